adc_ram_packer: RTL and testbench

- Capture-side writer for the ADC sample RAM that matrix_adc_top reads through adc_adr/adc_ramN_rdat; one instance per ADC lane.
- Takes a 10-bit ADC sample stream after a trigger and packs it densely, with no padding, into 256-bit words.
- Writes the words to consecutive RAM addresses 0..DEPTH-1, so a full capture of 32x4096 samples lands in exactly 5120 words, matching the reader's addressing.

---
 rtl/adc_ram_packer.sv | 140 ++++++++++++++
 tb/tb_adc_ram_packer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/adc_ram_packer.sv
// Packs a triggered stream of 10-bit ADC samples densely into 256-bit RAM words,
// written LSB-first to consecutive addresses starting at 0.
module adc_ram_packer #(
  parameter int unsigned SAMPLES = 131072,
  parameter int unsigned ADDR_W  = 13,
  parameter int unsigned DEPTH   = 5120
) (
  input  logic              clk_250MHz,
  input  logic              rst,
  input  logic              trg,
  input  logic              smp_valid,
  input  logic [9:0]        smp_dat,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_wadrs,
  output logic [255:0]      ram_wdat,
  output logic              busy,
  output logic              done,
  output logic              ovf
);

  localparam int unsigned CntW  = $clog2(SAMPLES + 1);
  localparam int unsigned Words = (SAMPLES * 10 + 255) / 256;

  if (Words > DEPTH) begin : g_depth_chk
    $error("adc_ram_packer: capture does not fit in DEPTH words");
  end
  if (DEPTH > (1 << ADDR_W)) begin : g_addr_chk
    $error("adc_ram_packer: DEPTH exceeds the ADDR_W address space");
  end

  typedef enum logic [2:0] {StIdle, StCapture, StFlush, StDrain, StDone} state_e;

  state_e              state_q, state_d;
  logic                trg_q;
  logic [255:0]        acc_q;
  logic [7:0]          fill_q;
  logic [CntW-1:0]     cnt_q;
  logic [ADDR_W-1:0]   adr_q;
  logic                wen_q;
  logic [ADDR_W-1:0]   wadrs_q;
  logic [255:0]        wdat_q;
  logic                ovf_q;

  logic                trg_edge;
  logic                take;
  logic                last;
  logic [8:0]          fill_sum;
  logic                emit;
  logic [7:0]          fill_new;
  logic [265:0]        merged;
  logic [255:0]        acc_new;
  logic                late_valid;

  assign trg_edge   = trg & ~trg_q;
  assign take       = (state_q == StCapture) && smp_valid;
  assign last       = (cnt_q == CntW'(SAMPLES - 1));
  assign fill_sum   = {1'b0, fill_q} + 9'd10;
  assign emit       = fill_sum[8];
  // Low byte of the sum is the new fill both with and without an emitted word.
  assign fill_new   = fill_sum[7:0];
  assign merged     = {10'b0, acc_q} | ({256'b0, smp_dat} << fill_q);
  assign acc_new    = emit ? {246'b0, merged[265:256]} : merged[255:0];
  assign late_valid = smp_valid &&
                      (state_q == StFlush || state_q == StDrain || state_q == StDone);

  always_ff @(posedge clk_250MHz) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (trg_edge) state_d = StCapture;
      StCapture: if (take && last) state_d = (fill_new != 8'd0) ? StFlush : StDrain;
      StFlush:   state_d = StDrain;
      StDrain:   state_d = StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q != StIdle);
    done = (state_q == StDone);
  end

  always_ff @(posedge clk_250MHz) begin
    if (!rst) begin
      trg_q   <= 1'b0;
      acc_q   <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      adr_q   <= '0;
      wen_q   <= 1'b0;
      wadrs_q <= '0;
      wdat_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      trg_q <= trg;
      wen_q <= 1'b0;
      if (state_q == StIdle && trg_edge) begin
        acc_q  <= '0;
        fill_q <= '0;
        cnt_q  <= '0;
        adr_q  <= '0;
        ovf_q  <= 1'b0;
      end
      if (take) begin
        acc_q  <= acc_new;
        fill_q <= fill_new;
        cnt_q  <= cnt_q + CntW'(1);
        if (emit) begin
          wen_q   <= 1'b1;
          wadrs_q <= adr_q;
          wdat_q  <= merged[255:0];
          adr_q   <= adr_q + ADDR_W'(1);
        end
      end
      // Bits above fill are always zero, so the accumulator is already padded.
      if (state_q == StFlush) begin
        wen_q   <= 1'b1;
        wadrs_q <= adr_q;
        wdat_q  <= acc_q;
      end
      if (late_valid) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign ram_wen   = wen_q;
  assign ram_wadrs = wadrs_q;
  assign ram_wdat  = wdat_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_adc_ram_packer.sv
// Directed bench: dut A (1280 samples, exactly 50 words) and dut B (30 samples, needs a flush).
module tb_adc_ram_packer;

  localparam int unsigned NA = 1280;
  localparam int unsigned NB = 30;

  logic clk = 1'b0;
  always #2 clk = ~clk;

  logic         a_rst, a_trg, a_valid, a_wen, a_busy, a_done, a_ovf;
  logic [9:0]   a_dat;
  logic [12:0]  a_wadrs;
  logic [255:0] a_wdat;
  logic         b_rst, b_trg, b_valid, b_wen, b_busy, b_done, b_ovf;
  logic [9:0]   b_dat;
  logic [12:0]  b_wadrs;
  logic [255:0] b_wdat;

  adc_ram_packer #(.SAMPLES(NA), .ADDR_W(13), .DEPTH(50)) u_dut_a (
    .clk_250MHz(clk), .rst(a_rst), .trg(a_trg), .smp_valid(a_valid), .smp_dat(a_dat),
    .ram_wen(a_wen), .ram_wadrs(a_wadrs), .ram_wdat(a_wdat), .busy(a_busy), .done(a_done),
    .ovf(a_ovf)
  );

  adc_ram_packer #(.SAMPLES(NB), .ADDR_W(13), .DEPTH(2)) u_dut_b (
    .clk_250MHz(clk), .rst(b_rst), .trg(b_trg), .smp_valid(b_valid), .smp_dat(b_dat),
    .ram_wen(b_wen), .ram_wadrs(b_wadrs), .ram_wdat(b_wdat), .busy(b_busy), .done(b_done),
    .ovf(b_ovf)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [255:0] aq_dat[$];
  int unsigned  aq_adr[$];
  int unsigned  aq_cyc[$];
  int unsigned  ad_cyc[$];
  logic [255:0] bq_dat[$];
  int unsigned  bq_adr[$];
  int unsigned  bq_cyc[$];
  int unsigned  bd_cyc[$];

  always @(negedge clk) begin
    if (a_wen) begin
      aq_dat.push_back(a_wdat);
      aq_adr.push_back(int'(a_wadrs));
      aq_cyc.push_back(cyc);
    end
    if (a_done) ad_cyc.push_back(cyc);
    if (b_wen) begin
      bq_dat.push_back(b_wdat);
      bq_adr.push_back(int'(b_wadrs));
      bq_cyc.push_back(cyc);
    end
    if (b_done) bd_cyc.push_back(cyc);
  end

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Word w of the stream where sample k carries the value k mod 1024.
  function automatic logic [255:0] ramp_word(input int unsigned w);
    logic [255:0] r;
    logic [9:0]   s;
    int unsigned  g;
    r = '0;
    for (int b = 0; b < 256; b++) begin
      g    = 256 * w + b;
      s    = 10'((g / 10) % 1024);
      r[b] = s[g % 10];
    end
    return r;
  endfunction

  task automatic a_trigger();
    a_trg = 1'b1;
    step();
    a_trg = 1'b0;
  endtask

  logic [255:0] exp_w;
  int unsigned  s_cyc;

  initial begin
    a_rst = 1'b0; a_trg = 1'b0; a_valid = 1'b0; a_dat = '0;
    b_rst = 1'b0; b_trg = 1'b0; b_valid = 1'b0; b_dat = '0;
    repeat (3) step();
    check_eq("rst_wen", a_wen, 0);
    check_eq("rst_busy", a_busy, 0);
    check_eq("rst_done", a_done, 0);
    check_eq("rst_ovf", a_ovf, 0);
    check_eq("rst_wadrs", a_wadrs, 0);
    check_eq("rst_wdat", a_wdat, 0);
    a_rst = 1'b1;
    b_rst = 1'b1;
    step();

    // 26 samples of k+1 complete word 0; keep going to 40 samples, then reset mid-capture.
    aq_dat.delete(); aq_adr.delete(); aq_cyc.delete();
    a_trigger();
    check_eq("t1_busy", a_busy, 1);
    s_cyc = 0;
    for (int k = 0; k < 40; k++) begin
      a_valid = 1'b1;
      a_dat   = 10'(k + 1);
      step();
      if (k == 25) s_cyc = cyc;
    end
    a_valid = 1'b0;
    exp_w = '0;
    for (int k = 0; k < 25; k++) exp_w[10*k +: 10] = 10'(k + 1);
    exp_w[255:250] = 6'h1A;
    check_eq("t1_nwrites", aq_dat.size(), 1);
    check_eq("t1_adr", (aq_adr.size() > 0) ? aq_adr[0] : 32'hFFFF, 0);
    check_eq("t1_lat", (aq_cyc.size() > 0) ? aq_cyc[0] : 0, s_cyc);
    check_eq("t1_word", (aq_dat.size() > 0) ? aq_dat[0] : '0, exp_w);

    a_rst = 1'b0;
    step();
    check_eq("mrst_wen", a_wen, 0);
    check_eq("mrst_busy", a_busy, 0);
    check_eq("mrst_ovf", a_ovf, 0);
    check_eq("mrst_wadrs", a_wadrs, 0);
    check_eq("mrst_wdat", a_wdat, 0);
    check_eq("mrst_nwrites", aq_dat.size(), 1);
    a_rst = 1'b1;
    step();

    // Full gap-free ramp capture.
    aq_dat.delete(); aq_adr.delete(); aq_cyc.delete(); ad_cyc.delete();
    a_trigger();
    for (int k = 0; k < int'(NA); k++) begin
      a_valid = 1'b1;
      a_dat   = 10'(k % 1024);
      step();
    end
    a_valid = 1'b0;
    for (int i = 0; i < 10 && !a_done; i++) step();
    check_eq("ramp_done_seen", a_done, 1);
    check_eq("ramp_busy_done", a_busy, 1);
    check_eq("ramp_ovf", a_ovf, 0);
    // Sample a stray strobe in the done cycle: must set sticky ovf.
    a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    check_eq("ramp_busy_after", a_busy, 0);
    check_eq("ramp_ndone", ad_cyc.size(), 1);
    check_eq("ramp_nwrites", aq_dat.size(), 50);
    for (int w = 0; w < aq_dat.size(); w++) begin
      check_eq($sformatf("ramp_adr%0d", w), aq_adr[w], w);
      check_eq($sformatf("ramp_dat%0d", w), aq_dat[w], ramp_word(w));
    end
    if (aq_cyc.size() > 0 && ad_cyc.size() > 0)
      check_eq("ramp_done_lat", ad_cyc[0], aq_cyc[aq_cyc.size() - 1] + 1);
    check_eq("ovf_set", a_ovf, 1);
    repeat (3) step();
    check_eq("ovf_sticky", a_ovf, 1);

    // Gapped capture of 100 samples, with a stray trigger mid-capture.
    aq_dat.delete(); aq_adr.delete(); aq_cyc.delete();
    a_trigger();
    check_eq("ovf_clear", a_ovf, 0);
    for (int k = 0; k < 100; k++) begin
      if ($urandom_range(1) == 1) begin
        a_valid = 1'b0;
        step();
      end
      a_valid = 1'b1;
      a_dat   = 10'(k);
      a_trg   = (k == 50);
      step();
      a_trg   = 1'b0;
    end
    a_valid = 1'b0;
    repeat (3) step();
    check_eq("gap_busy", a_busy, 1);
    check_eq("gap_nwrites", aq_dat.size(), 3);
    for (int w = 0; w < aq_dat.size(); w++) begin
      check_eq($sformatf("gap_adr%0d", w), aq_adr[w], w);
      check_eq($sformatf("gap_dat%0d", w), aq_dat[w], ramp_word(w));
    end
    a_rst = 1'b0;
    step();

    // 30 all-ones samples: one full word, then a 44-bit flush word.
    b_trg = 1'b1;
    step();
    b_trg = 1'b0;
    for (int k = 0; k < int'(NB); k++) begin
      b_valid = 1'b1;
      b_dat   = 10'h3FF;
      step();
    end
    b_valid = 1'b0;
    for (int i = 0; i < 10 && !b_done; i++) step();
    check_eq("fl_done_seen", b_done, 1);
    step();
    check_eq("fl_nwrites", bq_dat.size(), 2);
    exp_w = '0;
    exp_w[43:0] = '1;
    if (bq_dat.size() == 2) begin
      check_eq("fl_adr0", bq_adr[0], 0);
      check_eq("fl_dat0", bq_dat[0], {256{1'b1}});
      check_eq("fl_adr1", bq_adr[1], 1);
      check_eq("fl_dat1", bq_dat[1], exp_w);
      check_eq("fl_done_lat", (bd_cyc.size() > 0) ? bd_cyc[0] : 0, bq_cyc[1] + 1);
    end
    check_eq("fl_ovf", b_ovf, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
